pipeline_debug_controller: RTL

- Host-side sequencer for the 5-stage MIPS pipeline; sits between the UART byte interface and the pipeline's clock-enable, flush and debug read ports.
- Loads program words into instruction memory.
- Runs the pipeline either continuously until HALT retires, or one cycle per step command.
- After each run or step, dumps PC, the register bank and the data memory back over the UART as a byte stream.

---
 rtl/pipeline_debug_controller_pkg.sv | 36 +++
 rtl/pipeline_debug_controller_dump_serializer.sv | 57 +++++
 rtl/pipeline_debug_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_debug_controller_pkg.sv
// Shared constants and types for the pipeline debug controller.
// Command bytes, FSM state encoding and dump geometry.
package pipeline_debug_controller_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_COUNT,
      LOAD_BYTES,
      LOAD_FLUSH,
      RUN,
      STEP,
      DUMP_FETCH,
      DUMP_LATCH,
      DUMP_SEND,
      DUMP_WAIT
   } state_e;

   localparam int unsigned DEF_N_REGS      = 32;
   localparam int unsigned DEF_N_MEM_WORDS = 32;

   // PC word, then the register bank, then the data memory window
   function automatic int unsigned dump_words(
      input int unsigned n_regs,
      input int unsigned n_mem
   );
      return 1 + n_regs + n_mem;
   endfunction

   localparam int unsigned DUMP_WORDS =
      dump_words(DEF_N_REGS, DEF_N_MEM_WORDS);

endpackage

// File: rtl/pipeline_debug_controller_dump_serializer.sv
// Word-to-byte shift register for the dump stream.
// Sends MSB first, one tx_start per byte, advances on ack.
module pipeline_debug_controller_dump_serializer
   import pipeline_debug_controller_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               load_i,
   input  logic [NB_DATA-1:0] word_i,
   input  logic               send_i,
   input  logic               ack_i,
   output logic [7:0]         tx_data_o,
   output logic               tx_start_o,
   output logic               last_o
);

   localparam int NB_BYTES = NB_DATA / 8;
   localparam int NB_CNT   = $clog2(NB_BYTES);

   logic [NB_DATA-1:0] shreg_q, shreg_d;
   logic [NB_CNT-1:0]  cnt_q, cnt_d;
   logic               start_q, start_d;

   // next state: load a fresh word, or shift out the byte just acked
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      start_d = send_i;
      if (load_i) begin
         shreg_d = word_i;
         cnt_d   = '0;
      end else if (ack_i) begin
         shreg_d = shreg_q << 8;
         cnt_d   = cnt_q + NB_CNT'(1);
      end
   end

   // serializer registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

   assign tx_data_o  = shreg_q[NB_DATA-1 -: 8];
   assign tx_start_o = start_q;
   assign last_o     = (cnt_q == NB_CNT'(NB_BYTES - 1));

endmodule

// File: rtl/pipeline_debug_controller.sv
// Host-side sequencer: program load, run/step and state dump
// between the UART byte interface and the MIPS pipeline.
module pipeline_debug_controller
   import pipeline_debug_controller_pkg::*;
#(
   parameter int NB_DATA      = 32,
   parameter int NB_IMEM_ADDR = 8,
   parameter int N_REGS       = 32,
   parameter int N_MEM_WORDS  = 32,
   parameter int NB_MEM_ADDR  = 5
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [7:0]              i_rx_data,
   input  logic                    i_rx_valid,
   output logic [7:0]              o_tx_data,
   output logic                    o_tx_start,
   input  logic                    i_tx_done,
   output logic                    o_pipe_enable,
   output logic                    o_pipe_flush,
   input  logic                    i_halt,
   input  logic [NB_DATA-1:0]      i_pc,
   output logic                    o_imem_we,
   output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
   output logic [NB_DATA-1:0]      o_imem_wdata,
   output logic [4:0]              o_dbg_reg_addr,
   input  logic [NB_DATA-1:0]      i_dbg_reg_data,
   output logic [NB_MEM_ADDR-1:0]  o_dbg_mem_addr,
   input  logic [NB_DATA-1:0]      i_dbg_mem_data,
   output logic                    o_busy
);

   localparam int N_WORDS  = dump_words(N_REGS, N_MEM_WORDS);
   localparam int NB_K     = $clog2(N_WORDS + 1);
   localparam int NB_BYTES = NB_DATA / 8;
   localparam int NB_BCNT  = $clog2(NB_BYTES);

   state_e                  state_q, state_d;
   logic                    en_q, en_d;
   logic                    we_q, we_d;
   logic [NB_IMEM_ADDR-1:0] iaddr_q, iaddr_d;
   logic [NB_DATA-1:0]      idata_q, idata_d;
   logic [NB_IMEM_ADDR-1:0] word_q, word_d;
   logic [8:0]              left_q, left_d;
   logic [NB_BCNT-1:0]      bcnt_q, bcnt_d;
   logic [NB_DATA-1:0]      asm_q, asm_d;
   logic [NB_K-1:0]         k_q, k_d;

   logic               ser_load, ser_send, ser_ack, ser_last;
   logic [NB_DATA-1:0] dump_word;

   // dump index selects PC, then register bank, then data memory
   always_comb begin
      dump_word = i_dbg_mem_data;
      if (k_q == '0) begin
         dump_word = i_pc;
      end else if (k_q <= NB_K'(N_REGS)) begin
         dump_word = i_dbg_reg_data;
      end
   end

   assign o_dbg_reg_addr =
      (k_q != '0 && k_q <= NB_K'(N_REGS)) ?
      5'(k_q - NB_K'(1)) : '0;
   assign o_dbg_mem_addr =
      (k_q > NB_K'(N_REGS)) ?
      NB_MEM_ADDR'(k_q - NB_K'(N_REGS + 1)) : '0;

   // next-state and datapath control
   always_comb begin
      state_d  = state_q;
      en_d     = 1'b0;
      we_d     = 1'b0;
      iaddr_d  = iaddr_q;
      idata_d  = idata_q;
      word_d   = word_q;
      left_d   = left_q;
      bcnt_d   = bcnt_q;
      asm_d    = asm_q;
      k_d      = k_q;
      ser_load = 1'b0;
      ser_send = 1'b0;
      ser_ack  = 1'b0;
      unique case (state_q)
         IDLE: begin
            k_d = '0;
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: state_d = LOAD_COUNT;
                  CMD_RUN: begin
                     if (i_halt) begin
                        state_d = DUMP_FETCH;
                     end else begin
                        state_d = RUN;
                        en_d    = 1'b1;
                     end
                  end
                  CMD_STEP: begin
                     state_d = STEP;
                     en_d    = ~i_halt;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         LOAD_COUNT: begin
            if (i_rx_valid) begin
               left_d  = (i_rx_data == 8'd0) ?
                         9'd256 : {1'b0, i_rx_data};
               word_d  = '0;
               bcnt_d  = '0;
               state_d = LOAD_BYTES;
            end
         end
         LOAD_BYTES: begin
            if (we_q) begin
               word_d = word_q + NB_IMEM_ADDR'(1);
               if (left_q == 9'd0) begin
                  state_d = LOAD_FLUSH;
               end
            end
            if (i_rx_valid && left_q != 9'd0) begin
               asm_d  = (asm_q << 8) | NB_DATA'(i_rx_data);
               bcnt_d = bcnt_q + NB_BCNT'(1);
               if (bcnt_q == NB_BCNT'(NB_BYTES - 1)) begin
                  we_d    = 1'b1;
                  iaddr_d = word_q;
                  idata_d = asm_d;
                  left_d  = left_q - 9'd1;
               end
            end
         end
         LOAD_FLUSH: state_d = IDLE;
         RUN: begin
            if (i_halt) begin
               state_d = DUMP_FETCH;
            end else begin
               en_d = 1'b1;
            end
         end
         STEP: state_d = DUMP_FETCH;
         DUMP_FETCH: state_d = DUMP_LATCH;
         DUMP_LATCH: begin
            ser_load = 1'b1;
            state_d  = DUMP_SEND;
         end
         DUMP_SEND: begin
            ser_send = 1'b1;
            state_d  = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            if (i_tx_done) begin
               ser_ack = 1'b1;
               if (!ser_last) begin
                  state_d = DUMP_SEND;
               end else if (k_q == NB_K'(N_WORDS - 1)) begin
                  state_d = IDLE;
               end else begin
                  k_d     = k_q + NB_K'(1);
                  state_d = DUMP_FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // controller state registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         iaddr_q <= '0;
         idata_q <= '0;
         word_q  <= '0;
         left_q  <= '0;
         bcnt_q  <= '0;
         asm_q   <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         we_q    <= we_d;
         iaddr_q <= iaddr_d;
         idata_q <= idata_d;
         word_q  <= word_d;
         left_q  <= left_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         k_q     <= k_d;
      end
   end

   pipeline_debug_controller_dump_serializer #(
      .NB_DATA (NB_DATA)
   ) u_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .load_i     (ser_load),
      .word_i     (dump_word),
      .send_i     (ser_send),
      .ack_i      (ser_ack),
      .tx_data_o  (o_tx_data),
      .tx_start_o (o_tx_start),
      .last_o     (ser_last)
   );

   assign o_pipe_enable = en_q;
   assign o_pipe_flush  = (state_q == LOAD_FLUSH);
   assign o_imem_we     = we_q;
   assign o_imem_addr   = iaddr_q;
   assign o_imem_wdata  = idata_q;
   assign o_busy        = (state_q != IDLE);

endmodule
